result_readback: RTL and testbench

// - Reads the TxT result matrix out of the C BRAM banks after compute: bank=row, addr=col, row-major order.
// - Streams each ACCW-bit element over a valid/ready interface to the host/DMA side.
// - Read-side counterpart of the PE controller's one-element-per-cycle STORE writer.
// - Covers the 1-cycle BRAM read latency with a credit-limited prefetch FIFO, so throughput is 1 beat/cycle under full ready.

---
 rtl/result_readback.sv | 184 ++++++++++++++++++
 tb/tb_result_readback.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_readback.sv
`timescale 1ns/1ps
// Streams the TxT C result matrix out of its row banks in row-major order over valid/ready.
// Optional READBACK_CLEAR_EN zeroes each element right after it is read.
module result_readback #(
  parameter int T       = 16,
  parameter int ACCW    = 32,
  parameter int BRAM_AW = 8,
  parameter int FIFO_D  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [T-1:0]                 bram_c_en,
  output logic [T-1:0][BRAM_AW-1:0]    bram_c_addr,
  input  logic [T-1:0][ACCW-1:0]       bram_c_rdata,
  output logic [T-1:0]                 bram_c_we,
  output logic [T-1:0][ACCW-1:0]       bram_c_wdata,
  output logic [ACCW-1:0]              m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         m_tlast
);
  localparam int RW = (T > 1) ? $clog2(T) : 1;
  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);
  localparam logic [RW-1:0] IDX_MAX = RW'(T - 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_D - 1);
  localparam logic [CW:0]   DEPTH   = (CW + 1)'(FIFO_D);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d, col_q, col_d;
  logic            inflight_q, inflight_d;
  logic [RW-1:0]   rd_row_q, rd_row_d;
  logic            rd_last_q, rd_last_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ACCW:0]   mem_q [FIFO_D];
  logic [ACCW:0]   mem_d [FIFO_D];
`ifdef READBACK_CLEAR_EN
  logic [RW-1:0]   rd_col_q, rd_col_d;
`endif

  logic            issue, push, pop, credit_ok, bank_conflict, fifo_full;
  logic [CW:0]     occupancy;

  assign push      = inflight_q;
  assign m_tvalid  = (count_q != '0);
  assign m_tdata   = mem_q[rd_ptr_q][ACCW-1:0];
  assign m_tlast   = m_tvalid & mem_q[rd_ptr_q][ACCW];
  assign pop       = m_tvalid & m_tready;
  assign fifo_full = (count_q == DEPTH[CW-1:0]);

  // Credit counts the read still in the BRAM pipe; pops this cycle are not credited.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign credit_ok = (occupancy < DEPTH);

`ifdef READBACK_CLEAR_EN
  // The clearing write owns the previous bank this cycle, so a read to it must wait.
  assign bank_conflict = inflight_q && (rd_row_q == row_q);
`else
  assign bank_conflict = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_READ: begin
        busy  = 1'b1;
        issue = credit_ok && !bank_conflict;
        if (issue) begin
          if (col_q == IDX_MAX) begin
            col_d = '0;
            if (row_q == IDX_MAX) begin
              row_d   = '0;
              state_d = S_FLUSH;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (pop && m_tlast) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = issue;
    rd_row_d   = row_q;
    rd_last_d  = (row_q == IDX_MAX) && (col_q == IDX_MAX);
`ifdef READBACK_CLEAR_EN
    rd_col_d   = col_q;
`endif
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {rd_last_q, bram_c_rdata[rd_row_q]};
      wr_ptr_d        = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_comb begin
    bram_c_en    = '0;
    bram_c_addr  = '0;
    bram_c_we    = '0;
    bram_c_wdata = '0;
`ifdef READBACK_CLEAR_EN
    if (inflight_q) begin
      bram_c_en[rd_row_q]   = 1'b1;
      bram_c_we[rd_row_q]   = 1'b1;
      bram_c_addr[rd_row_q] = BRAM_AW'(rd_col_q);
    end
`endif
    if (issue) begin
      bram_c_en[row_q]   = 1'b1;
      bram_c_addr[row_q] = BRAM_AW'(col_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      inflight_q <= 1'b0;
      rd_row_q   <= '0;
      rd_last_q  <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FIFO_D; i++) mem_q[i] <= '0;
`ifdef READBACK_CLEAR_EN
      rd_col_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      inflight_q <= inflight_d;
      rd_row_q   <= rd_row_d;
      rd_last_q  <= rd_last_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
`ifdef READBACK_CLEAR_EN
      rd_col_q   <= rd_col_d;
`endif
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_result_readback.sv
`timescale 1ns/1ps
// Bench for result_readback: bank model with 1-cycle read latency plus a row-major stream model.
module tb_result_readback;
  localparam int T = 16, ACCW = 32, BRAM_AW = 8, FIFO_D = 4, N = T * T;
  localparam int RUN_BUDGET = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst_n, start, busy, done, m_tvalid, m_tready, m_tlast;
  logic [T-1:0]               bram_c_en, bram_c_we;
  logic [T-1:0][BRAM_AW-1:0]  bram_c_addr;
  logic [T-1:0][ACCW-1:0]     bram_c_rdata, bram_c_wdata;
  logic [ACCW-1:0]            m_tdata;

  result_readback #(.T(T), .ACCW(ACCW), .BRAM_AW(BRAM_AW), .FIFO_D(FIFO_D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .bram_c_en(bram_c_en), .bram_c_addr(bram_c_addr), .bram_c_rdata(bram_c_rdata),
    .bram_c_we(bram_c_we), .bram_c_wdata(bram_c_wdata),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  int cmp_cnt = 0, err_cnt = 0;
  int beat_n, done_cnt, issue_cnt;
  bit we_seen;
  logic [ACCW-1:0] c_mem [T][1 << BRAM_AW];
  logic [ACCW-1:0] ref_c [T][T];
  logic [ACCW-1:0] exp_q [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++) begin
        c_mem[r][c] = ACCW'(r * 256 + c);
        ref_c[r][c] = ACCW'(r * 256 + c);
      end
  endtask

  // Expected stream is the matrix as it stands at start, row-major.
  task automatic arm();
    for (int n = 0; n < N; n++) exp_q[n] = ref_c[n / T][n % T];
    beat_n = 0;
    done_cnt = 0;
    issue_cnt = 0;
  endtask

  task automatic post_run();
`ifdef READBACK_CLEAR_EN
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++) ref_c[r][c] = '0;
`endif
  endtask

  task automatic backdoor(input string name);
    int bad;
    bad = 0;
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++) if (c_mem[r][c] !== ref_c[r][c]) bad++;
    check(name, bad, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_vld"}, m_tvalid, 1'b0);
    check({tag, "_en"}, bram_c_en, '0);
    check({tag, "_we"}, bram_c_we, '0);
  endtask

  // mode 0: ready=1; 1: 1,0,1,0 then random; 2: ready=0 for 50 cycles.
  // action 0: none; 1: start pulse at beat 100; 2: reset at beat 100.
  task automatic do_run(input int mode, input int action, output int first_vld, output int done_cyc);
    int cyc;
    bit fired;
    arm();
    m_tready = (mode != 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; first_vld = -1; done_cyc = -1; fired = 1'b0;
    while (done_cyc < 0 && cyc < RUN_BUDGET) begin
      if (mode == 2 && cyc == 50) begin
        check("stall_issues", issue_cnt, FIFO_D);
        check("stall_vld", m_tvalid, 1'b1);
        check("stall_dat", m_tdata, 0);
      end
      case (mode)
        1: m_tready = (cyc < 4) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
        2: m_tready = (cyc >= 50);
        default: m_tready = 1'b1;
      endcase
      if (m_tvalid && first_vld < 0) first_vld = cyc;
      if (done) done_cyc = cyc;
      start = 1'b0;
      if (action == 1 && !fired && beat_n >= 100) begin
        start = 1'b1;
        fired = 1'b1;
      end
      if (action == 2 && !fired && beat_n >= 100) begin
        fired = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle_outputs("midrst");
        break;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (action != 2) begin
      check("run_finished", done_cyc >= 0, 1'b1);
      check("beat_total", beat_n, N);
      repeat (3) tick();
      check("done_once", done_cnt, 1);
      post_run();
    end
  endtask

  initial begin
    int fv, dc;
    rst_n = 1'b0; start = 1'b0; m_tready = 1'b0; bram_c_rdata = '0;
    beat_n = 0; done_cnt = 0; issue_cnt = 0; we_seen = 1'b0;
    for (int n = 0; n < N; n++) exp_q[n] = '0;
    preload();
    fork
      begin : bank_proc
        logic [T-1:0] en_s, we_s;
        logic [T-1:0][BRAM_AW-1:0] addr_s;
        logic [T-1:0][ACCW-1:0] wd_s;
        forever begin
          @(negedge clk);
          en_s = bram_c_en; we_s = bram_c_we; addr_s = bram_c_addr; wd_s = bram_c_wdata;
          @(posedge clk);
          #1;
          for (int b = 0; b < T; b++)
            if (en_s[b]) begin
              bram_c_rdata[b] = c_mem[b][addr_s[b]];
              if (we_s[b]) c_mem[b][addr_s[b]] = wd_s[b];
            end
        end
      end
      begin : cmp_proc
        bit stall_prev;
        stall_prev = 1'b0;
        forever begin
          @(negedge clk);
          if (!rst_n) stall_prev = 1'b0;
          else begin
            if (stall_prev) check("vld_drop", m_tvalid, 1'b1);
            if (m_tvalid) begin
              if (beat_n < N) begin
                check($sformatf("beat_dat[%0d]", beat_n), m_tdata, exp_q[beat_n]);
                check($sformatf("beat_last[%0d]", beat_n), m_tlast, beat_n == N - 1);
              end else check("beat_overrun", beat_n, N - 1);
              if (m_tready) beat_n++;
            end
            stall_prev = m_tvalid && !m_tready;
            if (done) done_cnt++;
            if (|(bram_c_en & ~bram_c_we)) issue_cnt++;
            if (|bram_c_we) we_seen = 1'b1;
          end
        end
      end
    join_none

    repeat (3) tick();
    rst_n = 1'b1;
    check_idle_outputs("reset");
    check("reset_done", done, 1'b0);
    check("reset_last", m_tlast, 1'b0);
    check("reset_addr", bram_c_addr, '0);
    check("reset_wdata", bram_c_wdata, '0);

    // Full rate readout
    arm();
    check("model_first", exp_q[0], 0);
    check("model_b17", exp_q[17], 32'h0101);
    check("model_last", exp_q[N - 1], 32'h0F0F);
    do_run(0, 0, fv, dc);
`ifndef READBACK_CLEAR_EN
    check("first_vld_cyc", fv, 2);
    check("done_cyc", dc, 2 + N);
`endif
    backdoor("backdoor_after_run");

    // Start after done: new readout from C[0][0]
    do_run(0, 0, fv, dc);

    // Backpressure with an ignored start mid-stream
    preload();
    do_run(1, 1, fv, dc);

    // Sink stall then release
    preload();
    do_run(2, 0, fv, dc);

    // Reset at beat 100, then a clean full run
    preload();
    do_run(0, 2, fv, dc);
    repeat (2) tick();
    check_idle_outputs("post_rst");
    preload();
    do_run(0, 0, fv, dc);
    backdoor("backdoor_final");

`ifndef READBACK_CLEAR_EN
    check("we_never", we_seen, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
